// File: rtl/rom_scan_pkg.sv
// Shared definitions for the ROM scanner: state encoding, default geometry and
// the compare-pipeline depth that matches the registered ROM read.
package rom_scan_pkg;

  localparam int unsigned DEFAULT_DEPTH = 200;
  localparam int unsigned DEFAULT_AW    = 8;
  localparam int unsigned DEFAULT_DW    = 8;

  // One stage for the address register, one for the ROM output register.
  localparam int unsigned PIPE_LAT = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StScan  = ST_SCAN,
    StDrain = ST_DRAIN,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/scan_match_acc.sv
// Tag pipeline aligned to the ROM read latency plus the match accumulator
// (saturating count, found flag, first/last matching address).
module scan_match_acc
  import rom_scan_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW,
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          tag_valid,
  input  logic [AW-1:0] tag_addr,
  input  logic [DW-1:0] rom_data,
  input  logic [DW-1:0] key,
  output logic          found,
  output logic [7:0]    match_count,
  output logic [AW-1:0] first_addr,
  output logic [AW-1:0] last_addr
);

  logic [PIPE_LAT-1:0] vld_q;
  logic [AW-1:0]       tag_addr_q [PIPE_LAT];

  logic          found_q, found_d;
  logic [7:0]    count_q, count_d;
  logic [AW-1:0] first_q, first_d;
  logic [AW-1:0] last_q, last_d;
  logic          hit;

  assign hit = vld_q[PIPE_LAT-1] && (rom_data == key);

  always_comb begin
    found_d = found_q;
    count_d = count_q;
    first_d = first_q;
    last_d  = last_q;
    if (clear) begin
      found_d = 1'b0;
      count_d = '0;
      first_d = '0;
      last_d  = '0;
    end else if (hit) begin
      if (count_q != 8'hff) begin
        count_d = count_q + 8'd1;
      end
      found_d = 1'b1;
      last_d  = tag_addr_q[PIPE_LAT-1];
      if (!found_q) begin
        first_d = tag_addr_q[PIPE_LAT-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_addr_q[i] <= '0;
      end
      found_q <= 1'b0;
      count_q <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q         <= {vld_q[PIPE_LAT-2:0], tag_valid};
      tag_addr_q[0] <= tag_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
      found_q <= found_d;
      count_q <= count_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign found       = found_q;
  assign match_count = count_q;
  assign first_addr  = first_q;
  assign last_addr   = last_q;

endmodule

// File: rtl/rom_scan.sv
// Hardware sweep of a registered lookup ROM against a latched key.
// Optional completion interrupt is enabled by defining ROM_SCAN_IRQ_EN.
module rom_scan
  import rom_scan_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned DW    = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
`ifdef ROM_SCAN_IRQ_EN
  output logic          interrupt,
  input  logic          interrupt_ack,
`endif
  input  logic          start,
  input  logic [DW-1:0] key,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [7:0]    match_count,
  output logic [AW-1:0] first_addr,
  output logic [AW-1:0] last_addr
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] key_q, key_d;
  logic          drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;
  logic          tag_valid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    key_d     = key_q;
    drain_d   = drain_q;
    busy_d    = busy_q;
    done_d    = done_q;
    accept    = 1'b0;
    tag_valid = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          accept    = 1'b1;
          key_d     = key;
          addr_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          drain_d   = 1'b0;
          tag_valid = 1'b1;
          // A single-word ROM has already issued its only address.
          state_d   = (LastAddr == '0) ? StDrain : StScan;
        end
      end
      StScan: begin
        addr_d    = addr_q + AW'(1);
        tag_valid = 1'b1;
        drain_d   = 1'b0;
        if (addr_d == LastAddr) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      key_q   <= '0;
      drain_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      key_q   <= key_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  scan_match_acc #(
    .AW (AW),
    .DW (DW)
  ) u_acc (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept),
    .tag_valid   (tag_valid),
    .tag_addr    (addr_d),
    .rom_data    (rom_data),
    .key         (key_q),
    .found       (found),
    .match_count (match_count),
    .first_addr  (first_addr),
    .last_addr   (last_addr)
  );

`ifdef ROM_SCAN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (accept) begin
      irq_q <= 1'b0;
    end else if (done_d && !done_q) begin
      irq_q <= 1'b1;
    end else if (interrupt_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign interrupt = irq_q;
`endif

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/rom_scan.md
# rom_scan

Sequential scanner that sits directly upstream of the lookup ROM (`array_rom`: 8-bit address in, 8-bit data out, data registered on the clock).
- On a `start` strobe from the PicoBlaze port logic, it walks ROM addresses 0..DEPTH-1, one per cycle, and compares each returned byte against a latched key.
- It reports match count, first/last match address and a found flag back to the processor input ports.
- It replaces firmware-driven ROM polling with a fixed-latency hardware sweep.

## Interface
Parameters:
- `DEPTH`, 200: number of ROM words scanned (addresses 0..DEPTH-1); legal range 1..256.
- `AW`, 8: ROM address width.
- `DW`, 8: ROM data / key width.

Ports (one clock; `reset` is synchronous and active-high):
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `start`, in, 1: one-cycle scan request; honoured only in IDLE or DONE.
- `key`, in, DW: value to match; sampled on the accepted `start` edge only.
- `rom_addr`, out, AW: address to ROM.
- `rom_data`, in, DW: ROM output; holds `memory[addr]` one edge after `addr` is driven.
- `busy`, out, 1: high while a scan is in progress.
- `done`, out, 1: level; high from scan completion until the next accepted `start` or `reset`.
- `found`, out, 1: at least one match in the last scan.
- `match_count`, out, 8: number of matches, saturating at 255.
- `first_addr`, out, AW: lowest matching address; 0 if none.
- `last_addr`, out, AW: highest matching address; 0 if none.
- `interrupt`, out, 1: present only with `ROM_SCAN_IRQ_EN`.
- `interrupt_ack`, in, 1: present only with `ROM_SCAN_IRQ_EN`.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE/DONE → SCAN on `start`. On that edge:
    - latch `key`;
    - `rom_addr`←0;
    - clear `match_count`, `found`, `first_addr`, `last_addr`;
    - `done`←0, `busy`←1.
  - SCAN: `rom_addr` increments by 1 each edge. On the edge that would leave `rom_addr` = DEPTH-1, go to DRAIN; `rom_addr` holds at DEPTH-1 and does not wrap.
  - DRAIN: 2 edges to flush the compare pipeline, then go to DONE: `busy`←0, `done`←1.
- Compare pipeline:
  - 2-stage tag shift register of {valid, addr} aligned to ROM latency.
  - The address driven after edge e is compared against `rom_data` at edge e+2.
- On a valid compare with `rom_data == key`:
  - `match_count`++ (saturating at 255);
  - `found`←1;
  - `last_addr`←tag addr;
  - `first_addr`←tag addr only if `found` was 0.
- Results are frozen in DONE and stay readable until the next accepted `start`.
- `start` while `busy` is ignored; the key is not re-sampled.
- `start` in DONE restarts immediately; `done` falls on that edge.
- `reset` mid-scan aborts the scan. Next edge:
  - state = IDLE;
  - all outputs = 0, including `rom_addr`, `busy`, `done`, `found`, counts and addresses;
  - tag pipeline invalidated, so no late compare can update results.
- `reset` and `start` on the same edge: `reset` wins.

## Timing
- Accepted start at edge s: `rom_addr`=k during the cycle after edge s+k, for k = 0..DEPTH-1.
- Last compare at edge s+DEPTH+1; `done`=1 and `busy`=0 from edge s+DEPTH+1.
  - DEPTH=200: done after edge s+201.
- Back-to-back: `start` at edge s+DEPTH+1+1 or later begins a new scan with identical timing.
- All outputs are registered; no combinational path from `start`/`key` to outputs.

## Configuration
- `ROM_SCAN_IRQ_EN` defined:
  - `interrupt` rises on the same edge as `done`;
  - it stays high until the edge on which `interrupt_ack`=1, clearing on that edge;
  - it is cleared by `reset`;
  - an accepted `start` also clears it.
- Undefined: the `interrupt`/`interrupt_ack` ports do not exist; completion is signalled by `done` polling only.

## Structure
- Shared package `rom_scan_pkg`:
  - state encoding localparams (IDLE=0, SCAN=1, DRAIN=2, DONE=3);
  - default DEPTH/AW/DW constants;
  - `PIPE_LAT`=2.
- Sub-module `scan_match_acc`: tag pipeline plus compare/accumulate logic (count, found, first/last). The top level holds the FSM and address counter.

## Test plan
- Default ROM image, key=3 → `match_count`=14, `first_addr`=3, `last_addr`=182, `found`=1, `done` at edge s+201.
- Key=0 → count=1, first=last=0. Key=199 → count=1, first=last=199 (final-address boundary, no wrap).
- Key=200 → `found`=0, count=0, first=last=0, `done` still at s+201.
- `start` pulsed at s+50 during scan with key=150 → ignored; key=3 result unchanged. Second `start` in DONE, key=150 → `done` drops, then count=1, addr 150.
- `reset` at s+100 → all outputs 0 next edge; no further result updates; a new scan afterwards gives correct results.
- With `ROM_SCAN_IRQ_EN`: `interrupt` rises with `done`, holds while `interrupt_ack`=0 for 10 cycles, clears on the ack edge.
